// File: rtl/add_accumulator.sv
// rtl/add_accumulator.sv - multi-operand stream accumulator built around a ripple-carry adder
// The exact result of an accumulation is {carry_cnt, sum}.

module rca_nbit #(
    parameter int n = 16
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         c_in,
    output logic [n-1:0] s,
    output logic         c_out
);
    logic [n:0] c;

    assign c[0] = c_in;

    for (genvar i = 0; i < n; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign c_out = c[n];
endmodule

module add_accumulator #(
    parameter int N     = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [N-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [N-1:0]     sum,
    output logic [CNT_W-1:0] carry_cnt,
    output logic             busy,
    output logic             done
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [N-1:0]     sum_q, sum_d;
    logic [CNT_W-1:0] carry_q, carry_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [N-1:0]     rca_s;
    logic             rca_c;
    logic             accept;

    rca_nbit #(.n(N)) u_rca (
        .a     (sum_q),
        .b     (in_data),
        .c_in  (1'b0),
        .s     (rca_s),
        .c_out (rca_c)
    );

    // Ready depends on state only so no combinational path exists from in_valid.
    assign in_ready  = (state_q == S_ACCUM);
    assign accept    = in_ready && in_valid;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign sum       = sum_q;
    assign carry_cnt = carry_q;

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sum_d   = '0;
                    carry_d = '0;
                    rem_d   = len;
                    state_d = (len != '0) ? S_ACCUM : S_DONE;
                end
            end
            S_ACCUM: begin
                if (accept) begin
                    sum_d   = rca_s;
                    carry_d = carry_q + CNT_W'(rca_c);
                    rem_d   = rem_q - 1'b1;
                    if (rem_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sum_q   <= '0;
            carry_q <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            rem_q   <= rem_d;
        end
    end
endmodule
